rom_step_sequencer: RTL and testbench

- Drives the pump-pattern ROM's address input and steps through the stored sequence at a programmable rate.
- Consumes the ROM's byte output and registers it onto a stable pump/motor output bus.
- Sits directly upstream (address side) and downstream (data side) of the 32-entry pattern ROM, between it and the pump drivers.
- Supports one-shot or looped playback, and start/stop control from the top-level controller.

---
 rtl/rom_step_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rom_step_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_step_sequencer.sv
// rom_step_sequencer
// Generates addresses for the 32-entry pump-pattern ROM and steps through the
// stored sequence at a programmable rate. Each ROM byte is registered onto the
// pump output bus and held there for STEP_CYCLES clock cycles.
//
// Optional build macro: ROM_EOS_EN
//   When defined, a ROM byte of 8'hFF seen in FETCH is an end-of-sequence
//   marker. It wraps to address 0 if loop is set and stops otherwise.
//   When undefined, 8'hFF is an ordinary pattern byte.
//
// Parameters:
//   STEP_CYCLES  clock cycles each pattern byte is held (>= 2)
//   SEQ_LEN      number of ROM entries played, addresses 0..SEQ_LEN-1 (1..256)
//
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   start        level start request, honoured in IDLE or DONE
//   stop         abort request, honoured in every state (highest priority)
//   loop         1 = wrap to address 0 after the last entry, 0 = one-shot
//   rom_addr     ROM address (registered)
//   rom_data     ROM data, valid one rising edge after rom_addr changes
//   pump_out     registered pattern byte to the pump drivers
//   step_strobe  one-cycle pulse in the cycle pump_out takes a new value
//   busy         high in FETCH and HOLD
//   done         high in DONE
module rom_step_sequencer #(
  parameter int unsigned STEP_CYCLES = 1200000,
  parameter int unsigned SEQ_LEN     = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] pump_out,
  output logic       step_strobe,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     ADDR_W    = 8;
  localparam int unsigned     DATA_W    = 8;
  localparam int unsigned     CNT_W     = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_CYCLES - 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   pump_q,  pump_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                strobe_q, strobe_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      pump_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pump_q   <= pump_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pump_d   = pump_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      pump_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end
        end

        // rom_data now reflects the address set on the previous edge
        S_FETCH: begin
`ifdef ROM_EOS_EN
          if (rom_data == 8'hFF) begin
            // End marker: no output update; wrap costs one extra FETCH cycle
            if (loop) begin
              addr_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            pump_d   = rom_data;
            strobe_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_HOLD;
          end
`else
          pump_d   = rom_data;
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_HOLD;
`endif
        end

        // HOLD lasts STEP_CYCLES-1 cycles so that with FETCH a step is STEP_CYCLES
        S_HOLD: begin
          if (cnt_q == CNT_LAST) begin
            if (addr_q < ADDR_LAST) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end else if (loop) begin
              addr_d  = '0;
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  assign rom_addr    = addr_q;
  assign pump_out    = pump_q;
  assign step_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_rom_step_sequencer.sv
// Directed bench for rom_step_sequencer with STEP_CYCLES=4, SEQ_LEN=4 and a
// behavioural ROM that updates its data on the falling clock edge.
module tb_rom_step_sequencer;

  localparam int unsigned STEP = 4;
  localparam int unsigned LEN  = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] pump_out;
  logic       step_strobe;
  logic       busy;
  logic       done;

  logic [7:0] rom_mem [4];

  int n_cmp = 0;
  int n_err = 0;

  int         cyc;
  int         st_t[$];
  logic [7:0] st_v[$];
  logic [7:0] st_a[$];
  bit         saw_done;

  rom_step_sequencer #(
    .STEP_CYCLES(STEP),
    .SEQ_LEN    (LEN)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pump_out   (pump_out),
    .step_strobe(step_strobe),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // ROM registers its output on the falling edge
  always @(negedge clk) rom_data <= rom_mem[rom_addr[1:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    cyc = 0;
    st_t.delete();
    st_v.delete();
    st_a.delete();
    saw_done = 1'b0;
  endtask

  // Advance n cycles, logging every strobe with its cycle, byte and address
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cyc++;
      if (step_strobe) begin
        st_t.push_back(cyc);
        st_v.push_back(pump_out);
        st_a.push_back(rom_addr);
      end
      if (done) saw_done = 1'b1;
    end
  endtask

  // One-cycle start pulse; the log restarts at the sampling edge
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_log();
  endtask

  task automatic chk_strobes(input string tag, input int n, input int et[8],
                             input logic [7:0] ev[8]);
    check({tag, "_count"}, 32'(st_t.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_t%0d", tag, i), (i < st_t.size()) ? 32'(st_t[i]) : 32'hFFFF_FFFF,
            32'(et[i]));
      check($sformatf("%s_v%0d", tag, i), (i < st_v.size()) ? 32'(st_v[i]) : 32'hFFFF_FFFF,
            32'(ev[i]));
    end
  endtask

  initial begin
    rom_mem[0] = 8'h11;
    rom_mem[1] = 8'h22;
    rom_mem[2] = 8'h33;
    rom_mem[3] = 8'h44;

    // Reset values
    #12;
    check("rst_addr", 32'(rom_addr), 32'h0);
    check("rst_pump", 32'(pump_out), 32'h0);
    check("rst_strobe", 32'(step_strobe), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // One-shot playback
    loop = 1'b0;
    pulse_start();
    check("os_addr0", 32'(rom_addr), 32'h0);
    check("os_busy0", 32'(busy), 32'h1);
    run(20);
    chk_strobes("os", 4, '{1, 5, 9, 13, 0, 0, 0, 0},
                '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0});
    check("os_done", 32'(done), 32'h1);
    check("os_busy", 32'(busy), 32'h0);
    check("os_hold", 32'(pump_out), 32'h44);

    // Looped replay from DONE: wrap keeps 4-cycle spacing, address 3 -> 0
    loop = 1'b1;
    pulse_start();
    run(24);
    chk_strobes("lp", 6, '{1, 5, 9, 13, 17, 21, 0, 0},
                '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h0, 8'h0});
    check("lp_addr_wrap", (st_a.size() > 4) ? 32'(st_a[4]) : 32'hFF, 32'h0);
    check("lp_addr_last", (st_a.size() > 3) ? 32'(st_a[3]) : 32'hFF, 32'h3);
    check("lp_no_done", 32'(saw_done), 32'h0);
    check("lp_busy", 32'(busy), 32'h1);

    // Stop during HOLD of 0x22
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    pulse_start();
    run(6);
    check("sp_pre_pump", 32'(pump_out), 32'h22);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sp_pump", 32'(pump_out), 32'h0);
    check("sp_addr", 32'(rom_addr), 32'h0);
    check("sp_busy", 32'(busy), 32'h0);
    check("sp_done", 32'(done), 32'h0);
    check("sp_strobe", 32'(step_strobe), 32'h0);
    pulse_start();
    run(2);
    chk_strobes("sp_re", 1, '{1, 0, 0, 0, 0, 0, 0, 0},
                '{8'h11, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});

    // start and stop together in IDLE: stop wins
    stop = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    clear_log();
    run(4);
    check("ss_count", 32'(st_t.size()), 32'h0);
    check("ss_busy", 32'(busy), 32'h0);

    // start pulsed mid-sequence is ignored
    pulse_start();
    run(3);
    start = 1'b1;
    run(1);
    start = 1'b0;
    run(12);
    chk_strobes("mid", 4, '{1, 5, 9, 13, 0, 0, 0, 0},
                '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0});

    // Asynchronous reset between edges mid-HOLD
    tick();
    pulse_start();
    run(2);
    check("ar_pre_pump", 32'(pump_out), 32'h11);
    #3;
    rstn = 1'b0;
    #1;
    check("ar_pump", 32'(pump_out), 32'h0);
    check("ar_addr", 32'(rom_addr), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_strobe", 32'(step_strobe), 32'h0);
    #2;
    rstn = 1'b1;
    tick();
    pulse_start();
    check("ar_addr_start", 32'(rom_addr), 32'h0);
    run(6);
    chk_strobes("ar_re", 2, '{1, 5, 0, 0, 0, 0, 0, 0},
                '{8'h11, 8'h22, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});

`ifdef ROM_EOS_EN
    // End-of-sequence marker at address 1
    stop = 1'b1;
    tick();
    stop = 1'b0;
    rom_mem[1] = 8'hFF;
    loop = 1'b0;
    pulse_start();
    run(12);
    chk_strobes("eos_os", 1, '{1, 0, 0, 0, 0, 0, 0, 0},
                '{8'h11, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});
    check("eos_done", 32'(done), 32'h1);
    check("eos_hold", 32'(pump_out), 32'h11);

    loop = 1'b1;
    pulse_start();
    run(17);
    chk_strobes("eos_lp", 4, '{1, 6, 11, 16, 0, 0, 0, 0},
                '{8'h11, 8'h11, 8'h11, 8'h11, 8'h0, 8'h0, 8'h0, 8'h0});
    check("eos_lp_no_done", 32'(saw_done), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
